data_ram: RTL and testbench

Parametrised, handshaked data memory for the SimpleMIPSCPU memory stage, replacing the single-cycle word-only RAM. Supports byte/halfword/word loads and stores with sign/zero extension, alignment and range checking, a configurable number of wait states, and an optional multi-cycle clear-on-reset sequence. A request/ready handshake lets the pipeline stall on memory latency.

---
 rtl/data_ram.sv | 223 ++++++++++++++++++++++
 tb/tb_data_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram : handshaked data memory for the SimpleMIPSCPU memory stage.
//
// Byte / halfword / word loads and stores with sign or zero extension,
// alignment and range checking, and WAIT_CYCLES wait states between accepting
// a request and answering it. The pipeline stalls on Busy.
//
// Optional feature (compile-time macro DRAM_CLEAR_ON_RESET_EN):
//   defined     - after Rst falls the array is cleared one word per cycle
//                 (DEPTH cycles, Busy=1), then the block goes idle.
//   not defined - reset leaves the contents alone; power-up contents are
//                 undefined.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   ADDR_W      byte address width (>= log2(DEPTH)+2)
//   WAIT_CYCLES extra cycles between accept and response, 0..15
//
// Ports:
//   CLK       in   clock, rising edge
//   Rst       in   synchronous active-high reset
//   Req       in   access request, sampled only while Busy=0
//   WE        in   1 = store, 0 = load
//   Size      in   00 byte, 01 halfword, 10/11 word
//   Unsigned  in   loads zero-extend when 1, sign-extend when 0
//   Addr      in   byte address
//   WData     in   store data, right-aligned
//   RData     out  load result while Ready=1, otherwise 0
//   Ready     out  one-cycle completion pulse
//   AddrErr   out  qualifies Ready: misaligned or out-of-range access
//   Busy      out  no request can be accepted this cycle
// -----------------------------------------------------------------------------
module data_ram #(
   parameter int unsigned DEPTH       = 4096,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              CLK,
   input  logic              Rst,
   input  logic              Req,
   input  logic              WE,
   input  logic [1:0]        Size,
   input  logic              Unsigned,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WData,
   output logic [31:0]       RData,
   output logic              Ready,
   output logic              AddrErr,
   output logic              Busy
);

   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2
`ifdef DRAM_CLEAR_ON_RESET_EN
      ,ST_CLEAR = 2'd3
`endif
   } state_t;

`ifdef DRAM_CLEAR_ON_RESET_EN
   localparam state_t RST_STATE = ST_CLEAR;
`else
   localparam state_t RST_STATE = ST_IDLE;
`endif

   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic              uns;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   req_t              req_q, acc;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
`ifdef DRAM_CLEAR_ON_RESET_EN
   logic [IDX_W-1:0]  clr_q, clr_d;
`endif

   logic [31:0]       mem_q [DEPTH];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;

   logic              is_byte, is_half, is_word, addr_err, go;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       word, lane, load_val;

   // ---------------------------------------------------------------- FSM
   // NOTE: every signal written in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef DRAM_CLEAR_ON_RESET_EN
      clr_d   = clr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               if (WAIT_CYCLES == 0) state_d = ST_RESP;
               else                  state_d = ST_WAIT;
               cnt_d = CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
`ifdef DRAM_CLEAR_ON_RESET_EN
         ST_CLEAR: begin
            if (clr_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
            else                            clr_d   = clr_q + 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------- access datapath
   always_comb begin
      // With no wait states the access happens on the accepting edge, before
      // the request has been latched, so take the live inputs in IDLE.
      if (state_q == ST_IDLE) acc = '{we: WE, size: Size, uns: Unsigned, addr: Addr, wdata: WData};
      else                    acc = req_q;

      is_byte  = (acc.size == 2'b00);
      is_half  = (acc.size == 2'b01);
      is_word  = acc.size[1];
      idx      = acc.addr[IDX_W+1:2];
      addr_err = (is_half && acc.addr[0])
              || (is_word && (acc.addr[1:0] != 2'b00))
              || ((acc.addr >> (IDX_W + 2)) != '0);
      go       = (state_d == ST_RESP);

      word = mem_q[idx];
      lane = word >> {acc.addr[1:0], 3'b000};
      if (is_byte)      load_val = acc.uns ? {24'd0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
      else if (is_half) load_val = acc.uns ? {16'd0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
      else              load_val = word;

      rdata_d = '0;
      err_d   = 1'b0;
      if (go) begin
         err_d = addr_err;
         if (!acc.we && !addr_err) rdata_d = load_val;
      end

      // Store lanes: replicate the right-aligned data, enable only the target lanes.
      mem_idx = idx;
      if (is_byte) begin
         mem_be    = 4'b0001 << acc.addr[1:0];
         mem_wdata = {4{acc.wdata[7:0]}};
      end else if (is_half) begin
         mem_be    = acc.addr[1] ? 4'b1100 : 4'b0011;
         mem_wdata = {2{acc.wdata[15:0]}};
      end else begin
         mem_be    = 4'b1111;
         mem_wdata = acc.wdata;
      end
      // Rst at the performing edge drops the access: no commit.
      mem_we = go && acc.we && !addr_err && !Rst;

`ifdef DRAM_CLEAR_ON_RESET_EN
      if (state_q == ST_CLEAR) begin
         mem_we    = !Rst;
         mem_idx   = clr_q;
         mem_be    = 4'b1111;
         mem_wdata = '0;
      end
`endif
   end

   // ------------------------------------------------------------ registers
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef DRAM_CLEAR_ON_RESET_EN
         clr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef DRAM_CLEAR_ON_RESET_EN
         clr_q   <= clr_d;
`endif
         if (state_q == ST_IDLE && Req) req_q <= acc;
      end
   end

   // NOTE: the storage array is deliberately not reset; clearing it is the
   // job of the optional CLEAR sequence, which keeps it mappable to RAM.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign RData   = rdata_q;
   assign AddrErr = err_q;
   assign Ready   = (state_q == ST_RESP);
   assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_ram.sv
// -----------------------------------------------------------------------------
// tb_data_ram : scoreboard bench for data_ram (DEPTH=4096, WAIT_CYCLES=3).
// Requests push their hand-computed response, including the edge at which
// Ready must appear, into a queue; an independent monitor pops and compares on
// every Ready pulse and checks that outputs are 0 between pulses.
// -----------------------------------------------------------------------------
module tb_data_ram;

   localparam int DEPTH = 4096;
   localparam int WC    = 3;

   logic        CLK = 1'b0;
   logic        Rst, Req, WE, Unsigned;
   logic [1:0]  Size;
   logic [31:0] Addr, WData, RData;
   logic        Ready, AddrErr, Busy;

   always #5 CLK = ~CLK;

   data_ram #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(WC)) dut (
      .CLK(CLK), .Rst(Rst), .Req(Req), .WE(WE), .Size(Size), .Unsigned(Unsigned),
      .Addr(Addr), .WData(WData), .RData(RData), .Ready(Ready), .AddrErr(AddrErr),
      .Busy(Busy)
   );

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          edge_n;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   bit   mon_en      = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: independent of stimulus.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (Ready === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ready: got Ready=1 RData=%h AddrErr=%b, expected no response (cycle %0d)",
                        RData, AddrErr, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check({e.name, "_rdata"}, RData, e.rdata);
               check({e.name, "_err"}, 32'(AddrErr), 32'(e.err));
               check({e.name, "_ready_edge"}, 32'(cyc), 32'(e.edge_n));
            end
         end else begin
            check("idle_outputs", {Ready, AddrErr, 30'd0} | RData, 32'd0);
         end
      end
   end

   // Issue one request (called at a negedge); returns at the negedge after accept.
   task automatic access(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
      int guard = 0;
      while (Busy !== 1'b0 && guard < 10000) begin
         @(negedge CLK);
         guard++;
      end
      if (Busy !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_busy_timeout: got Busy=%b, expected 0 within 10000 cycles", name, Busy);
         return;
      end
      WE = we; Size = size; Unsigned = uns; Addr = addr; WData = wdata; Req = 1'b1;
      sb.push_back('{name, exp_rd, exp_err, cyc + 1 + WC});
      @(negedge CLK);
      Req = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      int guard;
      Rst = 1'b1; Req = 1'b0; WE = 1'b0; Size = 2'b10; Unsigned = 1'b0;
      Addr = '0; WData = '0;
      repeat (3) @(negedge CLK);

      // Reset state
`ifdef DRAM_CLEAR_ON_RESET_EN
      check("reset_busy", 32'(Busy), 32'd1);
`else
      check("reset_busy", 32'(Busy), 32'd0);
`endif
      check("reset_ready", 32'(Ready), 32'd0);
      check("reset_rdata", RData, 32'd0);
      check("reset_adderr", 32'(AddrErr), 32'd0);
      Rst    = 1'b0;
      mon_en = 1'b1;

`ifdef DRAM_CLEAR_ON_RESET_EN
      busy_cnt = 0;
      while (Busy === 1'b1 && busy_cnt < 10000) begin
         busy_cnt++;
         @(negedge CLK);
      end
      check("clear_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
      access("clear_load_0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
`endif

      // Loads with extension
      access("st_w_0x20",       1'b1, 2'b10, 1'b0, 32'h20, 32'h8081_82F3, 32'h0, 1'b0);
      access("ld_b_s_0x20",     1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFF_FFF3, 1'b0);
      access("ld_b_u_0x23",     1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
      access("ld_h_s_0x22",     1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_8081, 1'b0);
      access("ld_h_u_0x20",     1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_82F3, 1'b0);
      access("ld_b_s_0x22",     1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'hFFFF_FF81, 1'b0);
      access("ld_w_u_0x20",     1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h8081_82F3, 1'b0);

      // Partial stores keep the other lanes
      access("st_w_0x20_b",     1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
      access("st_b_0x21",       1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA, 32'h0, 1'b0);
      access("ld_w_0x20_merge", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122_AA44, 1'b0);
      access("st_h_0x22",       1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, 32'h0, 1'b0);
      access("ld_w_0x20_half",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);

      // Alignment and range errors
      access("st_w_mis_0x22",   1'b1, 2'b10, 1'b0, 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1);
      access("st_h_mis_0x21",   1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_5555, 32'h0, 1'b1);
      access("ld_h_mis_0x23",   1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1);
      access("ld_w_oor_0x4000", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1);
      access("st_b_oor_0x4020", 1'b1, 2'b00, 1'b0, 32'h4020, 32'h0000_0077, 32'h0, 1'b1);
      access("ld_w_0x20_kept",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);

      // Last word, and Size=11 treated as word
      access("st_w_0x3ffc",     1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFE_F00D, 32'h0, 1'b0);
      access("ld_s3_0x3ffc",    1'b0, 2'b11, 1'b1, 32'h3FFC, 32'h0, 32'hCAFE_F00D, 1'b0);
      access("st_w_0x40",       1'b1, 2'b10, 1'b0, 32'h40, 32'h5A5A_5A5A, 32'h0, 1'b0);

      // Req held high: accepts at T and T+5, responses at T+3 and T+8
      guard = 0;
      while (Busy !== 1'b0 && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      WE = 1'b0; Size = 2'b10; Unsigned = 1'b0; Addr = 32'h40; WData = '0; Req = 1'b1;
      sb.push_back('{"held_req_1", 32'h5A5A_5A5A, 1'b0, cyc + 1 + WC});
      sb.push_back('{"held_req_2", 32'h5A5A_5A5A, 1'b0, cyc + 1 + (WC + 2) + WC});
      repeat (6) @(negedge CLK);
      Req = 1'b0;

      // Store dropped by reset one cycle after accept
      access("st_dropped_0x40_placeholder", 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
      void'(sb.pop_back());  // this store must never respond
      Rst = 1'b1;
      @(negedge CLK);
      Rst = 1'b0;
`ifdef DRAM_CLEAR_ON_RESET_EN
      access("ld_after_rst_0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
`else
      check("rst_busy_low", 32'(Busy), 32'd0);
      access("ld_after_rst_0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h5A5A_5A5A, 1'b0);
`endif

      // Drain the scoreboard
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
